// File: rtl/mc_chroma_ver_buf.sv
// Row window buffer between the chroma horizontal and vertical interpolation
// stages. Collects horizontally filtered rows, keeps a sliding 4-row window
// and presents it as A/B/C/D tap rows, one output row per handshake.
module mc_chroma_ver_buf #(
    parameter int PIXEL_WIDTH = 8,
    parameter int BLK_W       = 4,
    parameter int BLK_H       = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start_i,
    input  logic [2:0]                     frac_x_i,
    input  logic [2:0]                     frac_y_i,
    input  logic                           row_valid_i,
    input  logic [BLK_W*2*PIXEL_WIDTH-1:0] row_data_i,
    output logic                           row_ready_o,
    output logic [BLK_W*2*PIXEL_WIDTH-1:0] tap_a_o,
    output logic [BLK_W*2*PIXEL_WIDTH-1:0] tap_b_o,
    output logic [BLK_W*2*PIXEL_WIDTH-1:0] tap_c_o,
    output logic [BLK_W*2*PIXEL_WIDTH-1:0] tap_d_o,
    output logic [2:0]                     frac_x_o,
    output logic [2:0]                     frac_y_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int IN_ROWS = BLK_H + 3;
    localparam int CW      = $clog2(IN_ROWS + 1);
    localparam int OW      = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   in_cnt;
    logic [OW-1:0]   out_cnt;
    logic            row_acc;
    logic            out_fire;
    logic            last_out;

    assign out_fire = out_valid_o && out_ready_i;
    assign last_out = out_fire && (out_cnt == OW'(BLK_H - 1));
    assign row_acc  = row_valid_i && row_ready_o;
    assign busy_o   = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and input handshake
    always_comb begin
        state_nxt   = state;
        row_ready_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                row_ready_o = 1'b1;
                if (row_valid_i && (in_cnt == CW'(2))) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                row_ready_o = (in_cnt < CW'(IN_ROWS)) && (!out_valid_o || out_ready_i);
                if (last_out) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Window shift, counters, latched fractions and output handshake flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tap_a_o     <= '0;
            tap_b_o     <= '0;
            tap_c_o     <= '0;
            tap_d_o     <= '0;
            frac_x_o    <= '0;
            frac_y_o    <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;

            if ((state == IDLE) && start_i) begin
                frac_x_o <= frac_x_i;
                frac_y_o <= frac_y_i;
                in_cnt   <= '0;
                out_cnt  <= '0;
            end

            if (row_acc) begin
                tap_a_o <= tap_b_o;
                tap_b_o <= tap_c_o;
                tap_c_o <= tap_d_o;
                tap_d_o <= row_data_i;
                in_cnt  <= in_cnt + CW'(1);
            end

            if (state == RUN) begin
                // Last output: the input side is exhausted, so no row can
                // arrive on this edge and the window simply goes idle.
                if (last_out) begin
                    out_valid_o <= 1'b0;
                    done_o      <= 1'b1;
                end else begin
                    if (out_fire) begin
                        out_cnt <= out_cnt + OW'(1);
                    end
                    if (row_acc) begin
                        out_valid_o <= 1'b1;
                    end else if (out_fire) begin
                        out_valid_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mc_chroma_ver_buf.md
Name: mc_chroma_ver_buf

Overview:
- Row window buffer between the chroma horizontal interpolation stage and the chroma vertical interpolation stage.
- Accepts horizontally filtered rows of a chroma block, one row per handshake.
- Keeps a sliding 4-row window and presents it as the A/B/C/D tap rows to the vertical filter, one output row per handshake.
- Sequences one block per start pulse and reports completion.

Parameters:
- PIXEL_WIDTH, 8, pixel bit depth; each intermediate sample is 2*PIXEL_WIDTH bits, signed.
- BLK_W, 4, samples per row (columns processed in parallel).
- BLK_H, 4, output rows per block; the block consumes BLK_H+3 input rows.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse that begins a block; honoured only in IDLE
- frac_x_i  in  3  horizontal fraction, latched on an accepted start
- frac_y_i  in  3  vertical fraction, latched on an accepted start
- row_valid_i  in  1  input row valid
- row_data_i  in  BLK_W*2*PIXEL_WIDTH  input row; sample k at bits [k*2*PIXEL_WIDTH +: 2*PIXEL_WIDTH]
- row_ready_o  out  1  input row accepted when row_valid_i && row_ready_o
- tap_a_o  out  BLK_W*2*PIXEL_WIDTH  oldest window row
- tap_b_o  out  BLK_W*2*PIXEL_WIDTH  second window row
- tap_c_o  out  BLK_W*2*PIXEL_WIDTH  third window row
- tap_d_o  out  BLK_W*2*PIXEL_WIDTH  newest window row
- frac_x_o  out  3  latched frac_x, valid while busy
- frac_y_o  out  3  latched frac_y, valid while busy
- out_valid_o  out  1  taps form a valid output row
- out_ready_i  in  1  downstream accepts the output row
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last output row is accepted

Behaviour:
- Reset (rstn=0 at a clk edge):
  - All outputs go to 0; state goes to IDLE.
  - Window registers, counters and latched fractions are cleared.
  - Reset mid-block abandons the block; no done_o is issued.
- States: IDLE, FILL, RUN.
- IDLE:
  - row_ready_o=0.
  - start_i=1 latches frac_x/frac_y, clears in_cnt and out_cnt, and moves to FILL.
- FILL:
  - row_ready_o=1.
  - Each accepted row shifts the window: a<=b, b<=c, c<=d, d<=row_data_i. in_cnt increments.
  - The 3rd accepted row (in_cnt 2->3) moves to RUN; out_valid_o stays 0.
- RUN:
  - row_ready_o = (in_cnt < BLK_H+3) && (!out_valid_o || out_ready_i).
  - An accepted row shifts the window as in FILL and sets out_valid_o=1 on the next cycle. Output latency is one cycle from the accepting edge.
  - out_valid_o && out_ready_i increments out_cnt.
  - If the same edge also accepts a row, the window shifts and out_valid_o stays 1; otherwise out_valid_o clears.
  - The acceptance with out_cnt==BLK_H-1 pulses done_o for one cycle and moves to IDLE. busy_o drops on that same edge.
- Back-pressure:
  - While out_valid_o && !out_ready_i, the taps and out_valid_o hold unchanged and row_ready_o=0.
- Ordering:
  - A row is never accepted in IDLE.
  - start_i in FILL or RUN is ignored.
  - start_i and row_valid_i in the same IDLE cycle: start is taken, the row is not accepted.
  - A new start_i is accepted in the cycle after done_o.
- Input rows:
  - Every block consumes exactly BLK_H+3 rows, regardless of the frac values.
  - When frac_y=0 the downstream stage uses only tap B.
- Arithmetic: no arithmetic on data. Samples pass through bit-exact as signed 2*PIXEL_WIDTH values.
- Counter widths: in_cnt holds 0..BLK_H+3; out_cnt holds 0..BLK_H-1. Neither counter wraps within a block.

Test Plan:
- Basic fill: reset, start with frac_x=3, frac_y=5. Feed 7 rows where every sample of row r equals r+1, with out_ready_i=1 throughout.
  - Expect 4 output rows.
  - Output i has A=i+1, B=i+2, C=i+3, D=i+4, i.e. first row A/B/C/D = 1/2/3/4, last row = 4/5/6/7.
  - frac_x_o=3, frac_y_o=5; done_o pulses once, on the edge that accepts output row 4.
- Back-pressure: as the basic fill, but hold out_ready_i=0 for 5 cycles at output row 2.
  - Taps stay at 2/3/4/5 and row_ready_o=0 for those cycles.
  - Rows 6 and 7 are accepted only after release; output order and values are unchanged.
- Signed pass-through: feed samples 16'h8000, 16'hFFFF and 16'h7FFF in mixed columns.
  - Each appears bit-exact in the correct column of the correct tap.
- Stray inputs: in IDLE, assert row_valid_i with no start → row_ready_o=0 and window unchanged. Assert start_i again during RUN → ignored.
  - Block completes with 4 outputs and one done_o.
- Reset mid-block: drop rstn after 5 rows have been accepted.
  - Next cycle: all outputs 0, state IDLE, no done_o.
  - A following full block produces correct taps with no stale data.
- Throughput: start, assert row_valid_i continuously with out_ready_i=1.
  - 7 rows accepted on 7 consecutive edges; out_valid_o high for 4 consecutive cycles; done_o on the 4th.
  - Back-to-back start in the cycle after done_o is accepted.
